// File: rtl/fp_sched_pkg.sv
// ---------------------------------------------------------------------------
// fp_sched_pkg
//
// Purpose:
//   Shared definitions for the FP operation scheduler: the FP unit control
//   codes, the FP funct encodings, the scheduler state enum, the default
//   per-class latencies and the funct -> control-code decode helper.
//
// Contents:
//   CTRL_*            4-bit control codes presented to the FP unit
//   FUNCT_*           6-bit funct encodings accepted from the requesters
//   DEF_*_LAT         default latencies (cycles) per operation class
//   LAST_GRANT_INIT   reset value of the arbiter last-grant register
//   sched_state_t     scheduler FSM states
//   decode_funct()    maps a funct field onto its FP control code
// ---------------------------------------------------------------------------
package fp_sched_pkg;

    // Control codes driven on fp_ctrl. ADD.S and SUB.S share one code; the
    // all-zero code marks an illegal funct and is never started on the unit.
    localparam logic [3:0] CTRL_ADD     = 4'b1101;
    localparam logic [3:0] CTRL_MUL     = 4'b1100;
    localparam logic [3:0] CTRL_CEQ     = 4'b1110;
    localparam logic [3:0] CTRL_CLT     = 4'b1111;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b0000;

    // funct encodings understood by the scheduler.
    localparam logic [5:0] FUNCT_ADD = 6'b000000;
    localparam logic [5:0] FUNCT_SUB = 6'b000001;
    localparam logic [5:0] FUNCT_MUL = 6'b000010;
    localparam logic [5:0] FUNCT_CEQ = 6'b000100;
    localparam logic [5:0] FUNCT_CLT = 6'b000110;

    // Default operation latencies in cycles (each legal in 1..15).
    localparam int DEF_ADD_LAT = 3;
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_CMP_LAT = 1;

    // Last-grant resets to requester 1 so requester 0 wins the first tie.
    localparam logic LAST_GRANT_INIT = 1'b1;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Map a funct field onto the FP unit control code; anything not listed
    // is illegal and decodes to CTRL_ILLEGAL.
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        logic [3:0] code;
        case (funct)
            FUNCT_ADD: code = CTRL_ADD;
            FUNCT_SUB: code = CTRL_ADD;
            FUNCT_MUL: code = CTRL_MUL;
            FUNCT_CEQ: code = CTRL_CEQ;
            FUNCT_CLT: code = CTRL_CLT;
            default:   code = CTRL_ILLEGAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fp_sched_arb.sv
// ---------------------------------------------------------------------------
// fp_sched_arb
//
// Purpose:
//   Two-input arbiter for the FP scheduler issue ports, together with the
//   last-grant register used for round-robin tie breaking.
//
// Configuration:
//   FP_SCHED_RR_EN  undefined (default): fixed priority, requester 0 wins
//                   every tie.
//                   defined: on a tie the requester not granted last wins.
//   A lone valid requester is always granted in both builds.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   valid0   in   requester 0 valid
//   valid1   in   requester 1 valid
//   arb_en   in   arbitration allowed this cycle (scheduler idle, no flush)
//   grant0   out  requester 0 granted (combinational)
//   grant1   out  requester 1 granted (combinational)
// ---------------------------------------------------------------------------
module fp_sched_arb
    import fp_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic arb_en,
    output logic grant0,
    output logic grant1
);

`ifdef FP_SCHED_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    // Requester that won the most recent handshake (0 or 1).
    logic last_grant;

    // A tie goes to requester 1 only in the round-robin build and only when
    // requester 0 was the last one granted; otherwise requester 0 wins.
    logic tie_to_1;
    assign tie_to_1 = RR_EN & ~last_grant;

    // Grants are a pure function of the valids so the ready outputs can
    // follow them in the same cycle. Nothing is granted while arbitration
    // is disabled.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_en) begin
            if (valid0 && valid1) begin
                grant0 = ~tie_to_1;
                grant1 = tie_to_1;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    // Every grant is a handshake (a grant implies its valid), so record the
    // winner whenever any grant is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= LAST_GRANT_INIT;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/fp_op_scheduler.sv
// ---------------------------------------------------------------------------
// fp_op_scheduler
//
// Purpose:
//   Accepts single-precision FP operations from two requesters, decodes the
//   funct field into an FP unit control code, starts the FP unit and counts
//   out the fixed latency of the operation class before signalling
//   completion. One operation is in flight at a time.
//
// Configuration:
//   FP_SCHED_RR_EN  selects round-robin tie breaking (see fp_sched_arb);
//                   fixed priority to requester 0 when undefined.
//
// Parameters:
//   ADD_LAT   cycles for ADD.S / SUB.S                      (1..15)
//   MUL_LAT   cycles for MUL.S                              (1..15)
//   CMP_LAT   cycles for C.EQ.S / C.LT.S and illegal funct  (1..15)
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   req0_valid   in   requester 0 (integer pipeline) has an op
//   req0_funct   in   requester 0 funct [5:0]
//   req0_ready   out  requester 0 accepted this cycle
//   req1_valid   in   requester 1 (secondary issue port) has an op
//   req1_funct   in   requester 1 funct [5:0]
//   req1_ready   out  requester 1 accepted this cycle
//   flush        in   abort the current op, return to idle
//   fp_start     out  one-cycle start pulse to the FP unit
//   fp_ctrl      out  FP unit control code [3:0]
//   busy         out  an op is in flight
//   done         out  one-cycle completion pulse
//   done_id      out  requester of the completed op
//   done_err     out  completed op had an illegal funct
// ---------------------------------------------------------------------------
module fp_op_scheduler
    import fp_sched_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [5:0] req0_funct,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [5:0] req1_funct,
    output logic       req1_ready,
    input  logic       flush,
    output logic       fp_start,
    output logic [3:0] fp_ctrl,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       done_err
);

    // Latencies narrowed to the width of the cycle counter.
    localparam logic [3:0] ADD_CNT = 4'(ADD_LAT);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] CMP_CNT = 4'(CMP_LAT);

    sched_state_t state;
    logic [3:0]   cnt;
    logic         id_q;
    logic         err_q;
    logic         done_q;

    logic         arb_en;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [5:0]   sel_funct;
    logic [3:0]   sel_ctrl;
    logic         sel_err;
    logic [3:0]   sel_lat;

    // Acceptance is only possible while idle, out of reset and with no flush
    // pending, so the ready outputs drop in the flush cycle as well.
    assign arb_en = (state == ST_IDLE) && !flush && rst_n;

    fp_sched_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .arb_en (arb_en),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // Decode the winning requester's funct into its control code, error flag
    // and latency so the FSM can capture all three on the handshake edge.
    always_comb begin
        sel_funct = grant1 ? req1_funct : req0_funct;
        sel_ctrl  = decode_funct(sel_funct);
        sel_err   = (sel_ctrl == CTRL_ILLEGAL);
        case (sel_ctrl)
            CTRL_ADD: sel_lat = ADD_CNT;
            CTRL_MUL: sel_lat = MUL_CNT;
            default:  sel_lat = CMP_CNT;
        endcase
    end

    // Scheduler FSM with registered outputs.
    //   IDLE: wait for a handshake, then capture code/id/err and load cnt.
    //   BUSY: fp_ctrl holds the code; fp_start is high only on the first
    //         cycle of a legal op; cnt counts the latency down and the FSM
    //         leaves on the cycle where it reads 1.
    //   DONE: one cycle of done, then back to IDLE with nothing accepted.
    // flush and reset both abandon the op in flight and clear the outputs,
    // so a completion for it can never appear later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            fp_start <= 1'b0;
            fp_ctrl  <= CTRL_ILLEGAL;
            busy     <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            fp_start <= 1'b0;
            fp_ctrl  <= CTRL_ILLEGAL;
            busy     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state    <= ST_BUSY;
                        cnt      <= sel_lat;
                        id_q     <= grant1;
                        err_q    <= sel_err;
                        fp_start <= ~sel_err;
                        fp_ctrl  <= sel_ctrl;
                        busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    fp_start <= 1'b0;
                    // Guarded decrement so the counter can never wrap.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    // A count of 0 cannot occur for legal latencies; treating
                    // it like 1 keeps the FSM from ever getting stuck.
                    if (cnt <= 4'd1) begin
                        state   <= ST_DONE;
                        fp_ctrl <= CTRL_ILLEGAL;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= 4'd0;
                    fp_start <= 1'b0;
                    fp_ctrl  <= CTRL_ILLEGAL;
                    busy     <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    // A flush arriving in the DONE cycle itself must still suppress the
    // completion, so the pulse is masked by flush; id and err are only
    // meaningful while done is high and read 0 otherwise.
    assign done     = done_q & ~flush;
    assign done_id  = done & id_q;
    assign done_err = done & err_q;

endmodule

// File: tb/tb_fp_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fp_op_scheduler
//
// Purpose:
//   Self-checking bench for fp_op_scheduler. A transaction-level model
//   tracks the op in flight as (accept cycle, latency, code, id, err) and
//   derives every expected output from the cycle offset since acceptance;
//   a compare process checks all outputs against it every cycle. Directed
//   scenarios add hand-computed literal expectations.
//
// Configuration:
//   FP_SCHED_RR_EN  must match the build of the design; selects the
//                   expected tie-breaking behaviour.
// ---------------------------------------------------------------------------
module tb_fp_op_scheduler;

    localparam int ADD_LAT = 3;
    localparam int MUL_LAT = 4;
    localparam int CMP_LAT = 1;

    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_MUL = 6'b000010;
    localparam logic [5:0] F_CEQ = 6'b000100;
    localparam logic [5:0] F_BAD = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [5:0] req0_funct;
    logic       req0_ready;
    logic       req1_valid;
    logic [5:0] req1_funct;
    logic       req1_ready;
    logic       flush;
    logic       fp_start;
    logic [3:0] fp_ctrl;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       done_err;

    int n_checks = 0;
    int n_errors = 0;

    fp_op_scheduler #(
        .ADD_LAT (ADD_LAT),
        .MUL_LAT (MUL_LAT),
        .CMP_LAT (CMP_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_funct (req0_funct),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_funct (req1_funct),
        .req1_ready (req1_ready),
        .flush      (flush),
        .fp_start   (fp_start),
        .fp_ctrl    (fp_ctrl),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .done_err   (done_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report it when it does not hold.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Drive all inputs for the coming cycle and let combinational outputs
    // settle before anyone samples them.
    task automatic apply_stimulus(input logic v0, input logic [5:0] f0,
                                  input logic v1, input logic [5:0] f1,
                                  input logic fl, input logic rn);
        req0_valid = v0;
        req0_funct = f0;
        req1_valid = v1;
        req1_funct = f1;
        flush      = fl;
        rst_n      = rn;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: one op in flight described by when it was accepted
    // and what it was. Output expectations come from k = cycles since the
    // accept cycle: BUSY spans k = 1..lat, the completion is at k = lat+1.
    // ---------------------------------------------------------------------
    bit         check_en = 1'b0;
    int         cyc      = 0;
    bit         m_active = 1'b0;
    int         m_acc    = 0;
    int         m_lat    = 0;
    logic [3:0] m_code   = 4'h0;
    bit         m_id     = 1'b0;
    bit         m_err    = 1'b0;
    bit         m_last   = 1'b1;

    function automatic void model_decode(input logic [5:0] f,
                                         output logic [3:0] code,
                                         output int lat);
        case (f)
            6'b000000, 6'b000001: begin code = 4'b1101; lat = ADD_LAT; end
            6'b000010:            begin code = 4'b1100; lat = MUL_LAT; end
            6'b000100:            begin code = 4'b1110; lat = CMP_LAT; end
            6'b000110:            begin code = 4'b1111; lat = CMP_LAT; end
            default:              begin code = 4'b0000; lat = CMP_LAT; end
        endcase
    endfunction

    // Compare process: at every falling edge compare the DUT with the model,
    // then advance the model by what happens at the next rising edge.
    always @(negedge clk) begin
        int         k;
        bit         e_start, e_done, e_r0, e_r1;
        logic [3:0] e_ctrl;
        logic [3:0] d_code;
        int         d_lat;

        cyc++;
        k       = cyc - m_acc;
        e_start = m_active && (k == 1) && !m_err;
        e_ctrl  = (m_active && k <= m_lat) ? m_code : 4'h0;
        e_done  = m_active && (k == m_lat + 1) && !flush;
        e_r0    = 1'b0;
        e_r1    = 1'b0;
        if (!m_active && rst_n && !flush) begin
            if (req0_valid && req1_valid) begin
`ifdef FP_SCHED_RR_EN
                e_r1 = (m_last == 1'b0);
                e_r0 = !e_r1;
`else
                e_r0 = 1'b1;
`endif
            end else begin
                e_r0 = req0_valid;
                e_r1 = req1_valid;
            end
        end

        if (check_en) begin
            check_output("busy",       busy,       m_active);
            check_output("fp_start",   fp_start,   e_start);
            check_output("fp_ctrl",    fp_ctrl,    e_ctrl);
            check_output("done",       done,       e_done);
            check_output("done_id",    done_id,    e_done & m_id);
            check_output("done_err",   done_err,   e_done & m_err);
            check_output("req0_ready", req0_ready, e_r0);
            check_output("req1_ready", req1_ready, e_r1);
        end

        if (!rst_n) begin
            m_active = 1'b0;
            m_last   = 1'b1;
        end else if (flush) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (e_r0 || e_r1) begin
                model_decode(e_r1 ? req1_funct : req0_funct, d_code, d_lat);
                m_active = 1'b1;
                m_acc    = cyc;
                m_lat    = d_lat;
                m_code   = d_code;
                m_id     = e_r1;
                m_err    = (d_code == 4'h0);
                m_last   = e_r1;
            end
        end else if (k == m_lat + 1) begin
            m_active = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Directed scenarios with literal expectations.
    // ---------------------------------------------------------------------
    bit grants[$];
    bit exp_grants[3];

    initial begin
`ifdef FP_SCHED_RR_EN
        exp_grants = '{1'b0, 1'b1, 1'b0};
`else
        exp_grants = '{1'b0, 1'b0, 1'b0};
`endif
        // Reset held for three edges.
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b0);
        tick();
        check_en = 1'b1;
        tick();
        tick();
        check_output("rst_busy",     busy,     1'b0);
        check_output("rst_fp_start", fp_start, 1'b0);
        check_output("rst_fp_ctrl",  fp_ctrl,  4'b0000);
        check_output("rst_done",     done,     1'b0);

        // req0 ADD.S accepted at t: start and code at t+1, done at t+4.
        $display("[TB] req0 ADD.S");
        apply_stimulus(1'b1, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        check_output("add_start", fp_start, 1'b1);
        check_output("add_ctrl",  fp_ctrl,  4'b1101);
        tick();
        tick();
        tick();
        check_output("add_done",     done,     1'b1);
        check_output("add_done_id",  done_id,  1'b0);
        check_output("add_done_err", done_err, 1'b0);
        tick();

        // req1 MUL.S: code held 4 cycles, done at t+5 from requester 1,
        // req0 waiting meanwhile and accepted once idle again.
        $display("[TB] req1 MUL.S with req0 waiting");
        apply_stimulus(1'b0, F_ADD, 1'b1, F_MUL, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b1, F_ADD, 1'b0, F_MUL, 1'b0, 1'b1);
        check_output("mul_start", fp_start, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            check_output("mul_ctrl_hold",  fp_ctrl,    4'b1100);
            check_output("mul_r0_blocked", req0_ready, 1'b0);
        end
        tick();
        check_output("mul_done",    done,    1'b1);
        check_output("mul_done_id", done_id, 1'b1);
        check_output("mul_done_ctrl", fp_ctrl, 4'b0000);
        tick();
        check_output("mul_r0_after", req0_ready, 1'b1);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        repeat (5) tick();

        // Three back-to-back C.EQ.S with both requesters valid, from reset.
        $display("[TB] tie between requesters");
        apply_stimulus(1'b0, F_CEQ, 1'b0, F_CEQ, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, F_CEQ, 1'b1, F_CEQ, 1'b0, 1'b1);
        check_output("tie_first_r0", req0_ready, 1'b1);
        check_output("tie_first_r1", req1_ready, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) apply_stimulus(1'b0, F_CEQ, 1'b0, F_CEQ, 1'b0, 1'b1);
            if (done === 1'b1) grants.push_back(done_id);
        end
        check_output("tie_count", grants.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < grants.size()) check_output("tie_grant", grants[i], exp_grants[i]);
        end
        tick();

        // Illegal funct: no start, zero code, done with error at t+2.
        $display("[TB] illegal funct");
        apply_stimulus(1'b1, F_BAD, 1'b0, F_ADD, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        check_output("ill_start", fp_start, 1'b0);
        check_output("ill_ctrl",  fp_ctrl,  4'b0000);
        check_output("ill_busy",  busy,     1'b1);
        tick();
        check_output("ill_done",     done,     1'b1);
        check_output("ill_done_err", done_err, 1'b1);
        check_output("ill_done_id",  done_id,  1'b0);
        tick();
        tick();

        // Flush in the second BUSY cycle of MUL.S; req0 accepted after.
        $display("[TB] flush during MUL.S");
        apply_stimulus(1'b1, F_MUL, 1'b0, F_ADD, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b1, F_ADD, 1'b0, F_ADD, 1'b1, 1'b1);
        check_output("fl_done",     done,       1'b0);
        check_output("fl_r0_block", req0_ready, 1'b0);
        tick();
        apply_stimulus(1'b1, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        check_output("fl_idle_busy", busy,       1'b0);
        check_output("fl_idle_ctrl", fp_ctrl,    4'b0000);
        check_output("fl_r0_accept", req0_ready, 1'b1);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        check_output("fl_new_start", fp_start, 1'b1);
        check_output("fl_new_ctrl",  fp_ctrl,  4'b1101);
        repeat (6) tick();

        // Flush while idle blocks acceptance of both requesters.
        $display("[TB] flush while idle");
        apply_stimulus(1'b1, F_ADD, 1'b1, F_MUL, 1'b1, 1'b1);
        check_output("fl_idle_r0", req0_ready, 1'b0);
        check_output("fl_idle_r1", req1_ready, 1'b0);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        check_output("fl_idle_stay", busy, 1'b0);
        tick();

        // Reset in BUSY: everything zero next cycle, no late done.
        $display("[TB] reset during BUSY");
        apply_stimulus(1'b0, F_ADD, 1'b1, F_ADD, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, F_ADD, 1'b0, F_ADD, 1'b0, 1'b1);
        check_output("rb_busy",     busy,     1'b0);
        check_output("rb_fp_start", fp_start, 1'b0);
        check_output("rb_fp_ctrl",  fp_ctrl,  4'b0000);
        check_output("rb_done",     done,     1'b0);
        repeat (6) tick();

        check_en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
